// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared register-index width, load funct3 encodings and FSM states
package wb_stage_pkg;

    localparam int ZCRV_REG_SIZE = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_DRAIN    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - byte/half/word lane select with sign or zero extension
module load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr)
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            2'd3:    w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        w_half = addr[1] ? word[31:16] : word[15:0];
    end

    // Reserved encodings fall into the default arm and behave as LW.
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: data = {24'b0, w_byte};
            F3_LH: begin
                data       = {{16{w_half[15]}}, w_half};
                misaligned = addr[0];
            end
            F3_LHU: begin
                data       = {16'b0, w_half};
                misaligned = addr[0];
            end
            default: misaligned = (addr != 2'b00);
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: registers ALU results and aligns load responses for the regfile
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ZCRV_REG_SIZE-1:0] mem_rd,
    input  logic                     mem_rd_en,
    input  logic [31:0]              mem_alu_result,
    input  logic                     mem_is_load,
    input  logic [2:0]               mem_funct3,
    input  logic                     dmem_rsp_valid,
    input  logic [31:0]              dmem_rsp_data,
    input  logic                     flush,
    output logic [31:0]              rddata_from_wb,
    output logic [ZCRV_REG_SIZE-1:0] rd_from_wb,
    output logic                     rd_en_from_wb,
    output logic                     misalign_err
);

    wb_state_t r_state;
    wb_state_t w_state_nxt;

    logic [ZCRV_REG_SIZE-1:0] r_ld_rd;
    logic                     r_ld_rd_en;
    logic [2:0]               r_ld_funct3;
    logic [1:0]               r_ld_addr;

    logic [31:0]              r_rddata;
    logic [ZCRV_REG_SIZE-1:0] r_rd;
    logic                     r_rd_en;
    logic                     r_misalign;

    logic        w_hs;
    logic        w_rsp_commit;
    logic [31:0] w_ld_data;
    logic        w_ld_misaligned;

    assign mem_ready    = (r_state == S_IDLE);
    assign w_hs         = mem_valid && mem_ready;
    assign w_rsp_commit = (r_state == S_WAIT_RSP) && dmem_rsp_valid && !flush;

    load_align u_load_align (
        .funct3     (r_ld_funct3),
        .addr       (r_ld_addr),
        .word       (dmem_rsp_data),
        .data       (w_ld_data),
        .misaligned (w_ld_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flush that coincides with the response consumes it; otherwise DRAIN eats the late word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs && mem_is_load && !flush) w_state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (dmem_rsp_valid)  w_state_nxt = S_IDLE;
                else if (flush)      w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (dmem_rsp_valid)  w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rd     <= '0;
            r_ld_rd_en  <= 1'b0;
            r_ld_funct3 <= 3'b0;
            r_ld_addr   <= 2'b0;
            r_rddata    <= 32'b0;
            r_rd        <= '0;
            r_rd_en     <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_rd_en    <= 1'b0;
            r_misalign <= 1'b0;
            if (w_hs && !flush && !mem_is_load) begin
                r_rddata <= mem_alu_result;
                r_rd     <= mem_rd;
                r_rd_en  <= mem_rd_en && (mem_rd != '0);
            end
            if (w_hs && !flush && mem_is_load) begin
                r_ld_rd     <= mem_rd;
                r_ld_rd_en  <= mem_rd_en;
                r_ld_funct3 <= mem_funct3;
                r_ld_addr   <= mem_alu_result[1:0];
            end
            if (w_rsp_commit) begin
                if (w_ld_misaligned) begin
                    r_misalign <= 1'b1;
                end else begin
                    r_rddata <= w_ld_data;
                    r_rd     <= r_ld_rd;
                    r_rd_en  <= r_ld_rd_en && (r_ld_rd != '0);
                end
            end
        end
    end

    assign rddata_from_wb = r_rddata;
    assign rd_from_wb     = r_rd;
    assign rd_en_from_wb  = r_rd_en;
    assign misalign_err   = r_misalign;

endmodule
